// File: rtl/fetch_stage_pkg.sv
// Shared fetch constants: next-PC select codes, extender-op codes, fetch window defaults.
// Also defines the F/D pipeline register layout.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_LIMIT = 32'h0000_6FFC;

    localparam logic [7:0] NPC_PC4    = 8'h00;
    localparam logic [7:0] NPC_BRANCH = 8'h01;
    localparam logic [7:0] NPC_JUMP   = 8'h02;
    localparam logic [7:0] NPC_JR     = 8'h03;

    localparam logic [7:0] EXT_ZERO = 8'h00;
    localparam logic [7:0] EXT_SIGN = 8'h01;
    localparam logic [7:0] EXT_LUI  = 8'h02;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        exc_adel;
    } fd_reg_t;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC select; relative and absolute targets are formed from the D instruction.
module npc
    import fetch_stage_pkg::*;
(
    input  logic [7:0]  npc_op,
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_index,
    input  logic        branch_taken,
    input  logic [31:0] d_rs_value,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc4       = f_pc + 32'd4;
    assign br_target = d_pc + 32'd4 + br_offset(d_index[15:0]);
    assign j_target  = {d_pc[31:28], d_index, 2'b00};

    always_comb begin
        next_pc = pc4;
        case (npc_op)
            NPC_BRANCH: next_pc = branch_taken ? br_target : pc4;
            NPC_JUMP:   next_pc = j_target;
            NPC_JR:     next_pc = d_rs_value;
            default:    next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select and the F/D pipeline register.
// The delay slot is always fetched; illegal fetches enter D as a flagged nop.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [7:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] d_rs_value,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_exc_adel
);

    logic [31:0] f_pc;
    logic [31:0] next_pc;
    logic        f_illegal;
    fd_reg_t     fd;

    npc u_npc (
        .npc_op       (npc_op),
        .f_pc         (f_pc),
        .d_pc         (fd.pc),
        .d_index      (fd.instr[25:0]),
        .branch_taken (branch_taken),
        .d_rs_value   (d_rs_value),
        .next_pc      (next_pc)
    );

    assign f_illegal = (f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_LIMIT);

    // A redirect seen during stall is simply dropped; it is re-derived from the held D next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc <= RESET_PC;
            fd   <= '0;
        end else if (!stall) begin
            f_pc        <= next_pc;
            fd.instr    <= f_illegal ? 32'h0 : imem_rdata;
            fd.pc       <= f_pc;
            fd.valid    <= 1'b1;
            fd.exc_adel <= f_illegal;
        end
    end

    assign imem_addr  = f_pc;
    assign d_instr    = fd.instr;
    assign d_pc       = fd.pc;
    assign d_pc8      = fd.pc + 32'd8;
    assign d_valid    = fd.valid;
    assign d_exc_adel = fd.exc_adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, branch/jump/jr redirects, stall, illegal fetch, async reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [7:0]  npc_op;
    logic        branch_taken;
    logic [31:0] d_rs_value;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic        d_exc_adel;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .d_rs_value   (d_rs_value),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .d_instr      (d_instr),
        .d_pc         (d_pc),
        .d_pc8        (d_pc8),
        .d_valid      (d_valid),
        .d_exc_adel   (d_exc_adel)
    );

    always #5 clk = ~clk;

    // Instruction memory image: a few control-flow words, pattern elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h3010: return 32'h1022_FFFC;  // beq, imm -4
            32'h3020: return 32'h0800_0C10;  // j -> 3040
            32'h3104: return 32'h0800_0C50;  // j -> 3140
            default:  return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] op, input logic tk, input logic [31:0] rs, input logic st);
        npc_op = op; branch_taken = tk; d_rs_value = rs; stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] f, input logic [31:0] pc,
                         input logic [31:0] ins, input logic exc);
        chk({tag, ".f_pc"}, imem_addr, f);
        chk({tag, ".d_pc"}, d_pc, pc);
        chk({tag, ".d_instr"}, d_instr, ins);
        chk({tag, ".d_exc"}, {31'd0, d_exc_adel}, {31'd0, exc});
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; npc_op = NPC_PC4; branch_taken = 1'b0; d_rs_value = '0;
        #12;
        chk("rst.f_pc", imem_addr, 32'h3000);
        chk("rst.d_pc", d_pc, 32'h0);
        chk("rst.d_instr", d_instr, 32'h0);
        chk("rst.d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst.d_exc", {31'd0, d_exc_adel}, 32'd0);
        @(negedge clk); reset = 1'b1;
        #1 chk("rel.d_valid_pre", {31'd0, d_valid}, 32'd0);

        // Sequential fetch
        step(NPC_PC4, 0, 0, 0);
        chk_d("seq0", 32'h3004, 32'h3000, 32'h5A5A_3000, 0);
        chk("seq0.d_valid", {31'd0, d_valid}, 32'd1);
        chk("seq0.d_pc8", d_pc8, 32'h3008);
        step(NPC_PC4, 0, 0, 0);
        chk_d("seq1", 32'h3008, 32'h3004, 32'h5A5A_3004, 0);

        // Taken branch: D=beq@3010, F=3014 (delay slot), then 3004
        step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0);
        chk_d("br_d", 32'h3014, 32'h3010, 32'h1022_FFFC, 0);
        step(NPC_BRANCH, 1, 0, 0);
        chk_d("br_tk", 32'h3004, 32'h3014, 32'h5A5A_3014, 0);

        // Not taken
        step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0);
        step(NPC_BRANCH, 0, 0, 0);
        chk_d("br_nt", 32'h3018, 32'h3014, 32'h5A5A_3014, 0);

        // Jump from 3020, delay slot 3024, then 3040; then jr 3100
        step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0);
        chk_d("j_d", 32'h3024, 32'h3020, 32'h0800_0C10, 0);
        step(NPC_JUMP, 0, 0, 0);
        chk_d("j", 32'h3040, 32'h3024, 32'h5A5A_3024, 0);
        step(NPC_JR, 0, 32'h3100, 0);
        chk_d("jr", 32'h3100, 32'h3040, 32'h5A5A_3040, 0);

        // Stall 3 cycles with jump held in D
        step(NPC_PC4, 0, 0, 0); step(NPC_PC4, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(NPC_JUMP, 0, 0, 1);
            chk_d("stall", 32'h3108, 32'h3104, 32'h0800_0C50, 0);
        end
        step(NPC_JUMP, 0, 0, 0);
        chk_d("stall_j", 32'h3140, 32'h3108, 32'h5A5A_3108, 0);

        // Misaligned jr target
        step(NPC_JR, 0, 32'h3002, 0);
        step(NPC_PC4, 0, 0, 0);
        chk_d("adel_mis", 32'h3006, 32'h3002, 32'h0, 1);
        chk("adel_mis.pc8", d_pc8, 32'h300A);
        // Above limit
        step(NPC_JR, 0, 32'h7000, 0);
        step(NPC_PC4, 0, 0, 0);
        chk_d("adel_hi", 32'h7004, 32'h7000, 32'h0, 1);
        step(NPC_PC4, 0, 0, 0);
        chk_d("adel_hi2", 32'h7008, 32'h7004, 32'h0, 1);
        // Limit itself is legal
        step(NPC_JR, 0, 32'h6FFC, 0);
        step(NPC_PC4, 0, 0, 0);
        chk_d("lim", 32'h7000, 32'h6FFC, 32'h5A5A_6FFC, 0);
        // Below base and wraparound
        step(NPC_JR, 0, 32'hFFFF_FFFC, 0);
        step(NPC_PC4, 0, 0, 0);
        chk_d("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1);
        step(NPC_PC4, 0, 0, 0);
        chk_d("lo", 32'h4, 32'h0, 32'h0, 1);

        // Async reset mid-stall with a jump pending
        step(NPC_JR, 0, 32'h3104, 0);
        step(NPC_PC4, 0, 0, 0);
        step(NPC_JUMP, 0, 0, 1);
        chk_d("pre_rst", 32'h3108, 32'h3104, 32'h0800_0C50, 0);
        #2 reset = 1'b0;
        #1;
        chk_d("arst", 32'h3000, 32'h0, 32'h0, 0);
        chk("arst.d_valid", {31'd0, d_valid}, 32'd0);
        @(posedge clk); #1;
        // Release while stalled: first edge holds
        @(negedge clk); reset = 1'b1;
        step(NPC_JUMP, 0, 0, 1);
        chk("rel_st.f_pc", imem_addr, 32'h3000);
        chk("rel_st.d_valid", {31'd0, d_valid}, 32'd0);
        step(NPC_PC4, 0, 0, 0);
        chk_d("rel_go", 32'h3004, 32'h3000, 32'h5A5A_3000, 0);
        chk("rel_go.d_valid", {31'd0, d_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have parameter IM_BASE, default 32'h0000_3000, the lowest legal fetch address.
REQ-003 SHALL have parameter IM_LIMIT, default 32'h0000_6FFC, the highest legal fetch address.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port stall  input  1  from the hazard unit; holds the PC and the F/D register.
REQ-007 SHALL have port npc_op  input  8  next-PC select from the decode-stage controller.
REQ-008 SHALL have port branch_taken  input  1  comparator result for the branch held in D.
REQ-009 SHALL have port d_rs_value  input  32  forwarded rs value for jr/jalr.
REQ-010 SHALL have port imem_addr  output  32  current F-stage PC.
REQ-011 SHALL have port imem_rdata  input  32  instruction word at imem_addr, combinational, same cycle.
REQ-012 SHALL have port d_instr  output  32  instruction in D; its [15:0] drives the immediate extender.
REQ-013 SHALL have port d_pc  output  32  PC of the instruction in D.
REQ-014 SHALL have port d_pc8  output  32  d_pc+8, the link value.
REQ-015 SHALL have port d_valid  output  1  D holds a fetched instruction, not a reset bubble.
REQ-016 SHALL have port d_exc_adel  output  1  the D instruction came from an illegal fetch address.

Function
REQ-017 SHALL hold F_PC in a 32-bit register; imem_addr = F_PC combinationally.
REQ-018 SHALL compute next PC from npc_op: npcPC4 -> F_PC+4; npcBranch -> branch_taken ? d_pc+4+(sext(d_instr[15:0])<<2) : F_PC+4; npcJump -> {d_pc[31:28], d_instr[25:0], 2'b00}; npcJr -> d_rs_value.
REQ-019 SHALL treat any undefined npc_op code as npcPC4.
REQ-020 SHALL perform all PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 = 0.
REQ-021 SHALL, on a rising edge with stall=0, load F_PC <= next PC and load D <= {imem_rdata, F_PC, exception flag}, with d_valid <= 1.
REQ-022 SHALL, on a rising edge with stall=1, hold F_PC and all D outputs unchanged; a redirect requested during stall is ignored and re-evaluated next cycle from the same D contents.
REQ-023 SHALL always fetch the delay-slot instruction: a redirect takes effect on the fetch after the one in progress, with no flush.
REQ-024 SHALL flag a fetch illegal when F_PC[1:0] != 0, F_PC < IM_BASE, or F_PC > IM_LIMIT.
REQ-025 SHALL, for an illegal fetch, load d_instr = 32'h0 (nop) and d_exc_adel = 1 instead of imem_rdata.
REQ-026 SHALL keep the fetch sequence running after an illegal fetch; exception handling is downstream.
REQ-027 SHALL drive d_pc8 = d_pc+8 combinationally.
REQ-028 SHALL have latency of one cycle from F to D; throughput of one instruction per unstalled cycle.

Reset
REQ-029 SHALL, while reset=0, asynchronously force F_PC=RESET_PC, d_instr=0, d_pc=0, d_valid=0, d_exc_adel=0.
REQ-030 SHALL, on deassertion of reset, fetch from RESET_PC at the first rising edge; stall on that edge still holds.
REQ-031 SHALL, on reset asserted mid-stall or mid-redirect, discard the pending redirect; no state survives.

Structure
REQ-032 SHALL take npcPC4, npcBranch, npcJump, npcJr as 8-bit codes from the shared constants.v, alongside the extender-op codes.
REQ-033 SHALL define RESET_PC/IM_BASE/IM_LIMIT defaults in constants.v.
REQ-034 SHALL contain one sub-module, npc (combinational next-PC mux); the PC and F/D registers stay in fetch_stage.

Verification
REQ-035 SHALL verify reset release, no stall, npc_op=npcPC4: imem_addr 3000,3004,3008; d_pc trails by one cycle; d_valid=0 until the first edge.
REQ-036 SHALL verify a taken branch: D beq at 3010, imm16=16'hFFFC -> delay slot 3014 fetched, then 3004; not-taken -> 3018.
REQ-037 SHALL verify a jump and jr: j with index 26'h0000C10 at d_pc 3020 -> target 3040 after the delay slot; jr with d_rs_value=32'h3100 -> 3100.
REQ-038 SHALL verify stall=1 for 3 cycles with npcJump asserted: F_PC and D frozen; the jump resolves on the first unstalled edge.
REQ-039 SHALL verify jr to 32'h3002 and to 32'h7000: d_exc_adel=1, d_instr=0, then fetching continues at +4.
REQ-040 SHALL verify reset asserted between clock edges during stall: outputs go to reset values immediately, not at the next edge.
